// File: rtl/and_gate.sv
// and_gate: per-bit synchronized, registered AND of a and b; x = AND result, x_rise = one-cycle pulse on each 0->1 of x
module and_gate #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_rise
);
  logic [WIDTH-1:0] a_sync, b_sync, x_next;
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign a_sync = a;
      assign b_sync = b;
    end else begin : g_sync
      logic [WIDTH-1:0] a_q [SYNC_STAGES];
      logic [WIDTH-1:0] b_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          a_q[0] <= a;
          b_q[0] <= b;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end
      assign a_sync = a_q[SYNC_STAGES-1];
      assign b_sync = b_q[SYNC_STAGES-1];
    end
  endgenerate
  assign x_next = a_sync & b_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      x_rise <= '0;
    end else begin
      x      <= x_next;
      x_rise <= x_next & ~x;
    end
  end
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: randomized and directed check of and_gate against a history-queue reference model
module tb_and_gate;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, x, x_rise;
  logic [3:0] hist[$];
  logic [3:0] ex, prev, exr, av, bv;
  int total = 0;
  int bad = 0;

  and_gate #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .x(x), .x_rise(x_rise)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [3:0] na, input logic [3:0] nb);
    @(negedge clk);
    a = na;
    b = nb;
    @(posedge clk);
    hist.push_back(na & nb);
    prev = ex;
    ex = (hist.size() >= 3) ? hist[hist.size()-3] : 4'b0000;
    exr = ex & ~prev;
    #1;
    chk("x", x, ex);
    chk("x_rise", x_rise, exr);
  endtask

  task automatic rst_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_x", x, 4'b0000);
    chk("rst_rise", x_rise, 4'b0000);
    hist.delete();
    ex = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    ex = '0;
    #3;
    chk("reset_x", x, 4'b0000);
    chk("reset_rise", x_rise, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step(4'b0000, 4'b0001);
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b0001);
    chk("x_before_3rd", x, 4'b0000);
    step(4'b0001, 4'b0001);
    chk("x_3rd_edge", x, 4'b0001);
    chk("rise_3rd_edge", x_rise, 4'b0001);
    step(4'b0001, 4'b0001);
    chk("rise_one_cycle", x_rise, 4'b0000);
    step(4'b0000, 4'b0001);
    step(4'b0000, 4'b0001);
    chk("x_hold_after_drop", x, 4'b0001);
    step(4'b0000, 4'b0001);
    chk("x_fall_3rd", x, 4'b0000);
    chk("no_rise_on_fall", x_rise, 4'b0000);
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001);
    chk("x_high_pre_reset", x, 4'b0001);
    rst_pulse();
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b0001);
    chk("x_low_after_release", x, 4'b0000);
    step(4'b0001, 4'b0001);
    chk("x_back_3rd", x, 4'b0001);
    chk("rise_after_reset", x_rise, 4'b0001);
    step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b1100, 4'b1010);
    step(4'b1100, 4'b1010);
    step(4'b1100, 4'b1010);
    chk("wide_x", x, 4'b1000);
    chk("wide_rise", x_rise, 4'b1000);
    step(4'b1100, 4'b1010);
    chk("wide_rise_off", x_rise, 4'b0000);
    step(4'b1111, 4'b1111);
    step(4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) step(4'b1111, 4'b1111);
    av = '0;
    bv = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) av = 4'($urandom);
      if ($urandom_range(0, 2) == 0) bv = 4'($urandom);
      step(av, bv);
      if ($urandom_range(0, 59) == 0) rst_pulse();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
